// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between fetch (IF) and load/store (DM); ARB_STARVE_GUARD_EN bounds IF starvation
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CW = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic sel_dm, arb, go, pick_dm, done;
    assign arb  = state == IDLE || state == RESP;
    assign go   = arb && (if_req || dm_req);
    assign done = state == WAIT && cnt == CW'(1);
    assign busy = state != IDLE;
`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve;
    assign pick_dm = dm_req && !(if_req && starve == SW'(STARVE_MAX));
    // count DM wins over a waiting IF; an IF win or an idle IF clears the count
    always_ff @(posedge clk or negedge reset)
        if (!reset) starve <= '0;
        else if (arb) starve <= (if_req && pick_dm) ? starve + 1'b1 : '0;
`else
    assign pick_dm = dm_req;
`endif
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    // next state: arbitrate in IDLE and RESP, single-cycle ISSUE, WAIT until the latency count expires
    always_comb begin
        state_nx = state;
        if (arb) state_nx = go ? ISSUE : IDLE;
        else if (state == ISSUE) state_nx = WAIT;
        else if (done) state_nx = RESP;
    end
    // registered strobes, latched request, latency counter and returned data
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt       <= '0;
            sel_dm    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en    <= go;
            if_gnt    <= go && !pick_dm;
            dm_gnt    <= go && pick_dm;
            if_rvalid <= done && !sel_dm;
            dm_rvalid <= done && sel_dm;
            if (go) begin
                sel_dm    <= pick_dm;
                mem_we    <= pick_dm && dm_we;
                mem_addr  <= pick_dm ? dm_addr : if_addr;
                mem_wdata <= pick_dm ? dm_wdata : '0;
            end
            cnt <= state == ISSUE ? CW'(MEM_LAT) : (state == WAIT ? cnt - 1'b1 : cnt);
            if (done && !sel_dm) if_rdata <= mem_rdata;
            if (done && sel_dm) dm_rdata <= mem_we ? '0 : mem_rdata;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-accurate memory model
module tb_mem_port_arbiter;
    localparam int AW = 16, DW = 32, LAT = 3, SMAX = 3;
    logic clk = 0, reset = 1;
    logic if_req = 0, dm_req = 0, dm_we = 0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0, failures = 0, cyc = 0;
    int gnt_cyc_if = 0, gnt_cyc_dm = 0, rv_cyc_dm = 0, last_en = 0;
    bit outstanding = 0;
    logic [DW-1:0] exp_if[$], exp_dm[$];
    bit exp_gnt[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] pipe [LAT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : {~a, a};
    endfunction

    // memory: writes land at the mem_en edge, read data appears exactly LAT cycles after mem_en
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 32'hBADBAD00;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        cyc <= cyc + 1;
    end
    assign mem_rdata = pipe[LAT-1];

    // monitor: grant order, access contents, latency, overlap and returned data
    always @(negedge clk) begin
        if (!reset) outstanding = 0;
        else begin
            if (mem_en || if_gnt || dm_gnt) begin
                chk("en_gnt", {mem_en, if_gnt ^ dm_gnt, if_gnt & dm_gnt}, 3'b110);
                chk("busy_issue", busy, 1);
                chk("overlap", outstanding, 0);
                outstanding = 1;
                last_en = cyc;
                chk("gnt_expected", exp_gnt.size() > 0, 1);
                if (exp_gnt.size() > 0) chk("gnt_order", dm_gnt, exp_gnt.pop_front());
                if (if_gnt) begin
                    gnt_cyc_if = cyc;
                    chk("if_mem_addr", mem_addr, if_addr);
                    chk("if_mem_we", mem_we, 0);
                end
                if (dm_gnt) begin
                    gnt_cyc_dm = cyc;
                    chk("dm_mem_addr", mem_addr, dm_addr);
                    chk("dm_mem_we", mem_we, dm_we);
                    if (dm_we) chk("dm_mem_wdata", mem_wdata, dm_wdata);
                end
            end
            if (if_rvalid) begin
                chk("if_rv_lat", cyc - gnt_cyc_if, LAT + 1);
                chk("if_rv_expected", exp_if.size() > 0, 1);
                if (exp_if.size() > 0) chk("if_rdata", if_rdata, exp_if.pop_front());
                outstanding = 0;
            end
            if (dm_rvalid) begin
                rv_cyc_dm = cyc;
                chk("dm_rv_lat", cyc - gnt_cyc_dm, LAT + 1);
                chk("dm_rv_expected", exp_dm.size() > 0, 1);
                if (exp_dm.size() > 0) chk("dm_rdata", dm_rdata, exp_dm.pop_front());
                outstanding = 0;
            end
        end
    end

    task automatic if_read(input logic [AW-1:0] a, output int n);
        if_addr = a;
        if_req = 1;
        exp_if.push_back(rd(a));
        n = 0;
        do begin @(negedge clk); n++; end while (!if_gnt && n < 300);
        chk("if_gnt_seen", if_gnt, 1);
        #1 if_req = 0;
    endtask

    task automatic dm_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        dm_we = we;
        dm_addr = a;
        dm_wdata = d;
        dm_req = 1;
        exp_dm.push_back(we ? '0 : rd(a));
        do begin @(negedge clk); n++; end while (!dm_gnt && n < 300);
        chk("dm_gnt_seen", dm_gnt, 1);
        #1 dm_req = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_if.size() > 0 || exp_dm.size() > 0) && n < 100) begin @(negedge clk); n++; end
        chk("drain", {busy, exp_if.size() == 0, exp_dm.size() == 0, exp_gnt.size() == 0}, 4'b0111);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ctl"}, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
        chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, e1;
        #1 reset = 0;
        repeat (3) @(negedge clk);
        rst_chk("reset");
        reset = 1;
        @(posedge clk);
        #1;
        // single IF read
        mem[16'h0004] = 32'hDEADBEEF;
        exp_gnt.push_back(0);
        if_read(16'h0004, w);
        chk("if_gnt_lat", w, 2);
        drain();
        chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);
        // simultaneous IF and DM: DM first, IF right after dm_rvalid
        mem[16'h0100] = 32'h0BADCAFE;
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        fork
            dm_access(0, 16'h0100, 0);
            if_read(16'h0008, w2);
        join
        chk("if_after_dm", gnt_cyc_if - rv_cyc_dm, 1);
        drain();
        // DM write then read back through IF
        exp_gnt.push_back(1);
        dm_access(1, 16'h0200, 32'h12345678);
        drain();
        chk("dm_wr_rdata", dm_rdata, 0);
        exp_gnt.push_back(0);
        if_read(16'h0200, w);
        drain();
        chk("wr_readback", if_rdata, 32'h12345678);
        // DM held continuously while IF waits
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 21; i++) exp_gnt.push_back(i != 3);
`else
        for (int i = 0; i < 21; i++) exp_gnt.push_back(i != 20);
`endif
        fork
            for (int i = 0; i < 20; i++) dm_access(0, 16'(16'h0300 + i), 0);
            if_read(16'h0010, w2);
        join
        drain();
        // IF request withdrawn before grant produces no transaction
        exp_gnt.push_back(1);
        fork
            dm_access(0, 16'h0020, 0);
            begin
                @(posedge clk);
                #1 if_addr = 16'h0030;
                if_req = 1;
                repeat (2) @(posedge clk);
                #1 if_req = 0;
            end
        join
        drain();
        // back-to-back IF requests: ISSUE follows RESP directly
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        if_read(16'h0040, w);
        e1 = last_en;
        if_read(16'h0044, w);
        chk("en_gap", last_en - e1, LAT + 2);
        drain();
        // reset during WAIT abandons the transaction
        exp_gnt.push_back(1);
        dm_access(0, 16'h0050, 0);
        @(posedge clk);
        #2 reset = 0;
        #1 rst_chk("async_rst");
        exp_dm.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1;
        repeat (8) @(negedge clk);
        chk("no_rv_after_rst", {if_rvalid, dm_rvalid, busy}, 0);
        @(posedge clk);
        #1;
        exp_gnt.push_back(0);
        if_read(16'h0004, w);
        chk("post_rst_lat", w, 2);
        drain();
        chk("post_rst_rdata", if_rdata, 32'hDEADBEEF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
